ascii_scroll_buffer: RTL and testbench

- Upstream feeder for the active-low ASCII-to-7-segment decoders.
- Stores a message of up to DEPTH ASCII characters, written one byte at a time over a valid/ready handshake.
- Presents a NUM_DIGITS-character window of the message that scrolls right-to-left at a programmable rate.
- Each window byte drives one decoder instance. Blank padding uses 0x20, which the decoder renders as all segments off.

---
 rtl/ascii_scroll_buffer.sv | 121 ++++++++++++
 tb/tb_ascii_scroll_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_scroll_buffer.sv
// ascii_scroll_buffer: message store feeding NUM_DIGITS ASCII-to-7-segment decoders.
// The message is shown scrolling right-to-left through a window that is padded with blanks.
// Ports:
//   Clock      - system clock; all state changes on the rising edge
//   nReset     - asynchronous active-low reset
//   CharIn     - ASCII character to append to the message
//   CharValid  - CharIn is valid this cycle
//   CharReady  - combinational; high when a character can be accepted (!full && !Clear)
//   Clear      - synchronous; empties the message and restarts the scroll
//   Enable     - 1 lets the scroll advance, 0 freezes it
//   Window     - registered window; the top byte is the leftmost digit
//   Length     - current message length in characters
module ascii_scroll_buffer #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned TICK_DIV   = 25000000
) (
  input  logic                      Clock,
  input  logic                      nReset,
  input  logic [7:0]                CharIn,
  input  logic                      CharValid,
  output logic                      CharReady,
  input  logic                      Clear,
  input  logic                      Enable,
  output logic [8*NUM_DIGITS-1:0]   Window,
  output logic [$clog2(DEPTH):0]    Length
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned PMAX = DEPTH + NUM_DIGITS;
  // offset + k is below 2*P, so the index width covers twice the largest period
  localparam int unsigned SW   = $clog2(2 * PMAX);
  localparam int unsigned TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0]  BLANK = 8'h20;

  logic [7:0]              r_buf [DEPTH];
  logic [LW-1:0]           r_len;
  logic [SW-1:0]           r_off;
  logic [TW-1:0]           r_cnt;
  logic [8*NUM_DIGITS-1:0] r_window;

  logic                    w_ready;
  logic                    w_wr;
  logic                    w_last_cnt;
  logic [SW-1:0]           w_period;
  logic [SW-1:0]           w_off_inc;
  logic [SW-1:0]           w_idx;
  logic [8*NUM_DIGITS-1:0] w_window_nxt;

  assign w_ready    = (r_len != LW'(DEPTH)) && !Clear;
  assign w_wr       = CharValid && w_ready;
  assign w_last_cnt = (r_cnt == TW'(TICK_DIV - 1));
  // Period of the padded stream; taken before any write on this edge
  assign w_period   = SW'(r_len) + SW'(NUM_DIGITS);
  assign w_off_inc  = r_off + SW'(1);

  assign CharReady = w_ready;
  assign Window    = r_window;
  assign Length    = r_len;

  // Message storage; contents are irrelevant beyond r_len so no reset
  always_ff @(posedge Clock) begin
    if (w_wr) begin
      r_buf[r_len[AW-1:0]] <= CharIn;
    end
  end

  // Length, scroll offset and tick counter
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_len <= '0;
      r_off <= '0;
      r_cnt <= '0;
    end else if (Clear) begin
      r_len <= '0;
      r_off <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_len <= r_len + LW'(1);
      end
      if (r_len == '0) begin
        r_off <= '0;
        r_cnt <= '0;
      end else if (Enable) begin
        if (w_last_cnt) begin
          r_cnt <= '0;
          r_off <= (w_off_inc == w_period) ? '0 : w_off_inc;
        end else begin
          r_cnt <= r_cnt + TW'(1);
        end
      end
    end
  end

  // Window digit k shows stream[(offset+k) mod P]; one conditional subtract does the mod
  always_comb begin
    w_window_nxt = {NUM_DIGITS{BLANK}};
    w_idx        = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      w_idx = r_off + SW'(k);
      if (w_idx >= w_period) begin
        w_idx = w_idx - w_period;
      end
      if ((r_len != '0) && (w_idx >= SW'(NUM_DIGITS))) begin
        w_window_nxt[8*(int'(NUM_DIGITS)-k)-1 -: 8] = r_buf[AW'(w_idx - SW'(NUM_DIGITS))];
      end
    end
  end

  // Window register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_window <= {NUM_DIGITS{BLANK}};
    end else begin
      r_window <= w_window_nxt;
    end
  end

endmodule

// File: tb/tb_ascii_scroll_buffer.sv
// Self-checking bench for ascii_scroll_buffer (NUM_DIGITS=4, DEPTH=8, TICK_DIV=3).
// A behavioural model predicts each edge's Window; predictions are queued and compared when sampled.
module tb_ascii_scroll_buffer;

  localparam int ND = 4;
  localparam int DP = 8;
  localparam int TD = 3;

  logic        Clock = 1'b0;
  logic        nReset;
  logic [7:0]  CharIn;
  logic        CharValid;
  logic        CharReady;
  logic        Clear;
  logic        Enable;
  logic [31:0] Window;
  logic [3:0]  Length;

  int total = 0;
  int bad   = 0;

  int          m_len;
  int          m_off;
  int          m_cnt;
  logic [7:0]  m_buf [DP];
  logic [31:0] sb_q [$];

  ascii_scroll_buffer #(
    .NUM_DIGITS (ND),
    .DEPTH      (DP),
    .TICK_DIV   (TD)
  ) u_dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .CharIn    (CharIn),
    .CharValid (CharValid),
    .CharReady (CharReady),
    .Clear     (Clear),
    .Enable    (Enable),
    .Window    (Window),
    .Length    (Length)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Window as the stream definition gives it, built explicitly and indexed with a true modulo
  function automatic logic [31:0] model_window();
    logic [7:0]  s [ND+DP];
    logic [31:0] w;
    int          p;
    p = m_len + ND;
    w = 32'h20202020;
    for (int i = 0; i < ND + DP; i++) begin
      s[i] = (i < ND || i >= p) ? 8'h20 : m_buf[i-ND];
    end
    if (m_len != 0) begin
      for (int k = 0; k < ND; k++) begin
        w[8*(ND-k)-1 -: 8] = s[(m_off + k) % p];
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    m_len = 0;
    m_off = 0;
    m_cnt = 0;
    sb_q.delete();
  endtask

  // One clock: predict, advance the model on the edge, compare on the falling edge
  task automatic cycle();
    logic [31:0] exp;
    logic        rdy;
    int          p;
    @(posedge Clock);
    sb_q.push_back(model_window());
    rdy = (m_len < DP) && !Clear;
    p   = m_len + ND;
    if (Clear) begin
      m_len = 0;
      m_off = 0;
      m_cnt = 0;
    end else begin
      if (m_len == 0) begin
        m_off = 0;
        m_cnt = 0;
      end else if (Enable) begin
        if (m_cnt == TD - 1) begin
          m_cnt = 0;
          m_off = (m_off + 1) % p;
        end else begin
          m_cnt++;
        end
      end
      if (CharValid && rdy) begin
        m_buf[m_len] = CharIn;
        m_len++;
      end
    end
    @(negedge Clock);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check("window", Window, exp);
    end
    check("length", 32'(Length), 32'(m_len));
    check("ready", 32'(CharReady), 32'((m_len < DP) && !Clear));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write_char(input logic [7:0] c);
    CharValid = 1'b1;
    CharIn    = c;
    cycle();
    CharValid = 1'b0;
  endtask

  initial begin
    logic [31:0] scroll_seq [6];
    scroll_seq = '{32'h20202048, 32'h20204849, 32'h20484920,
                   32'h48492020, 32'h49202020, 32'h20202020};

    nReset = 1'b0; CharIn = 8'h00; CharValid = 1'b0; Clear = 1'b0; Enable = 1'b0;
    model_reset();
    #12;
    check("rst_window", Window, 32'h20202020);
    check("rst_length", 32'(Length), 32'd0);
    check("rst_ready", 32'(CharReady), 32'd1);
    @(negedge Clock);
    nReset = 1'b1;

    // Two characters with the scroll frozen
    write_char(8'h48);
    write_char(8'h49);
    idle(20);
    check("frozen_len", 32'(Length), 32'd2);
    check("frozen_window", Window, 32'h20202020);

    // Scroll steps: offset moves every TD edges, Window follows one edge later
    Enable = 1'b1;
    idle(4);
    check("scroll_0", Window, scroll_seq[0]);
    for (int i = 1; i < 6; i++) begin
      idle(3);
      check($sformatf("scroll_%0d", i), Window, scroll_seq[i]);
    end

    // Fill past capacity; the ninth character must be refused
    Clear = 1'b1; Enable = 1'b0;
    cycle();
    Clear = 1'b0;
    CharValid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      CharIn = 8'(8'h41 + i);
      cycle();
      if (i == 7) check("full_ready", 32'(CharReady), 32'd0);
    end
    CharValid = 1'b0;
    check("full_len", 32'(Length), 32'd8);
    Enable = 1'b1;
    idle(40);

    // Clear colliding with a write during an active scroll
    Clear = 1'b1; CharValid = 1'b1; CharIn = 8'h5A;
    #1;
    check("clr_ready", 32'(CharReady), 32'd0);
    cycle();
    Clear = 1'b0; CharValid = 1'b0;
    check("clr_len", 32'(Length), 32'd0);
    cycle();
    check("clr_window", Window, 32'h20202020);
    idle(10);

    // Freeze at offset 2, then append while frozen and resume
    Enable = 1'b0;
    write_char(8'h48);
    write_char(8'h49);
    Enable = 1'b1;
    idle(6);
    Enable = 1'b0;
    cycle();
    check("freeze_a", Window, 32'h20204849);
    idle(10);
    check("freeze_b", Window, 32'h20204849);
    write_char(8'h4A);
    check("append_len", 32'(Length), 32'd3);
    Enable = 1'b1;
    idle(4);
    check("append_show", Window, 32'h2048494A);
    idle(3);
    check("append_next", Window, 32'h48494A20);
    idle(25);

    // Asynchronous reset away from any clock edge
    #2;
    nReset = 1'b0;
    #1;
    check("arst_window", Window, 32'h20202020);
    check("arst_length", 32'(Length), 32'd0);
    check("arst_ready", 32'(CharReady), 32'd1);
    model_reset();
    Enable = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
